// File: rtl/proc_control_fsm_pkg.sv
// proc_control_fsm_pkg: step codes, opcodes and IR field positions for the bus processor control unit
package proc_control_fsm_pkg;
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam int IR_W = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int X_HI = 5;
    localparam int X_LO = 3;
    localparam int Y_HI = 2;
    localparam int Y_LO = 0;
    localparam logic [2:0] OP_MV = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// dec3to8: 3-bit register index to 8-bit one-hot select
//   w  in  3  register index
//   en in  1  enable; all outputs 0 when low
//   y  out 8  one-hot select (bit w)
module dec3to8 (
    input  logic [2:0] w,
    input  logic       en,
    output logic [7:0] y
);
    assign y = en ? 8'b1 << w : 8'b0;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multicycle control unit sequencing R0..R7, A, G and the shared bus
//   Clock  in   clock, posedge
//   Resetn in   async reset, active-low
//   Run    in   start request, sampled only in T0
//   DIN    in   data / instruction word, IR <= DIN[DATA_W-1 -: 9]
//   Rin    out  one-hot register load enables
//   Rout   out  one-hot register bus-drive selects
//   DINout, Gout out  DIN / G drive the bus
//   Ain, Gin     out  load A / load G
//   AddSub out  0 = A+bus, 1 = A-bus
//   IRin   out  IR load strobe
//   Done   out  last step of an instruction
module proc_control_fsm
    import proc_control_fsm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREG = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              IRin,
    output logic              Done
);
    state_t          state, state_next;
    logic [IR_W-1:0] ir;
    logic [2:0]      op;
    logic [7:0]      rx, ry;

    assign op = ir[OP_HI:OP_LO];

    dec3to8 dec_x (.w(ir[X_HI:X_LO]), .en(Resetn), .y(rx));
    dec3to8 dec_y (.w(ir[Y_HI:Y_LO]), .en(Resetn), .y(ry));

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state <= T0;
            ir <= '0;
        end else begin
            state <= state_next;
            if (IRin) ir <= DIN[DATA_W-1 -: IR_W];
        end

    always_comb begin
        state_next = T0;
        Rin = '0;
        Rout = '0;
        DINout = 1'b0;
        Gout = 1'b0;
        Ain = 1'b0;
        Gin = 1'b0;
        AddSub = 1'b0;
        IRin = 1'b0;
        Done = 1'b0;
        case (state)
            T0: begin
                // Resetn gating keeps every output low while reset is held
                IRin = Run & Resetn;
                state_next = Run ? T1 : T0;
            end
            T1: case (op)
                OP_MV: begin
                    Rout = ry;
                    Rin = rx;
                    Done = 1'b1;
                end
                OP_MVI: begin
                    DINout = 1'b1;
                    Rin = rx;
                    Done = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    Rout = rx;
                    Ain = 1'b1;
                    state_next = T2;
                end
                default: Done = 1'b1;
            endcase
            T2: begin
                Rout = ry;
                Gin = 1'b1;
                AddSub = op == OP_SUB;
                state_next = T3;
            end
            T3: begin
                Gout = 1'b1;
                Rin = rx;
                Done = 1'b1;
            end
            default: state_next = T0;
        endcase
    end
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed-vector bench for proc_control_fsm
module tb_proc_control_fsm;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Run = 1'b0;
    logic [15:0] DIN = '0;
    logic [7:0]  Rin, Rout;
    logic        DINout, Gout, Ain, Gin, AddSub, IRin, Done;
    int          nerr = 0;
    int          nchk = 0;

    localparam logic [6:0] DI = 7'b1000000, GO = 7'b0100000, AI = 7'b0010000,
                           GI = 7'b0001000, AS = 7'b0000100, IR = 7'b0000010, DN = 7'b0000001;

    proc_control_fsm dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Rin(Rin), .Rout(Rout),
        .DINout(DINout), .Gout(Gout), .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .IRin(IRin), .Done(Done)
    );

    always #5 Clock = ~Clock;

    wire [22:0] outs = {Rin, Rout, DINout, Gout, Ain, Gin, AddSub, IRin, Done};

    function automatic logic [22:0] ex(input logic [7:0] rin, input logic [7:0] rout, input logic [6:0] f);
        return {rin, rout, f};
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y, 7'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic run, input logic [15:0] din, input logic [22:0] exp);
        Run = run;
        DIN = din;
        #1;
        check(tag, 32'(outs), 32'(exp));
        @(negedge Clock);
    endtask

    always @(negedge Clock) begin
        #2;
        if (Resetn)
            check("bus_excl_onehot",
                  32'(($countones({|Rout, DINout, Gout}) <= 1) && $onehot0(Rin) && $onehot0(Rout)), 32'd1);
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1);
    end

    initial begin
        Run = 1'b1;
        #1;
        check("reset_outputs", 32'(outs), 32'd0);
        @(negedge Clock);
        check("reset_held", 32'(outs), 32'd0);
        Resetn = 1'b1;
        // mvi R2, #A5
        step("mvi_t0", 1, ins(3'b001, 3'd2, 3'd0), ex(8'h00, 8'h00, IR));
        step("mvi_t1", 0, 16'h00A5, ex(8'h04, 8'h00, DI | DN));
        step("idle", 0, 16'h0000, ex(8'h00, 8'h00, 7'b0));
        // mv R5, R2
        step("mv_t0", 1, ins(3'b000, 3'd5, 3'd2), ex(8'h00, 8'h00, IR));
        step("mv_t1", 0, 16'hFFFF, ex(8'h20, 8'h04, DN));
        // add R1, R3
        step("add_t0", 1, ins(3'b010, 3'd1, 3'd3), ex(8'h00, 8'h00, IR));
        step("add_t1", 0, 16'h0000, ex(8'h00, 8'h02, AI));
        step("add_t2", 0, 16'h0000, ex(8'h00, 8'h08, GI));
        step("add_t3", 0, 16'h0000, ex(8'h02, 8'h00, GO | DN));
        // sub R1, R3
        step("sub_t0", 1, ins(3'b011, 3'd1, 3'd3), ex(8'h00, 8'h00, IR));
        step("sub_t1", 0, 16'h0000, ex(8'h00, 8'h02, AI));
        step("sub_t2", 0, 16'h0000, ex(8'h00, 8'h08, GI | AS));
        step("sub_t3", 0, 16'h0000, ex(8'h02, 8'h00, GO | DN));
        // NOP
        step("nop_t0", 1, ins(3'b111, 3'd0, 3'd0), ex(8'h00, 8'h00, IR));
        step("nop_t1", 0, 16'h0000, ex(8'h00, 8'h00, DN));
        step("nop_idle", 0, 16'h0000, ex(8'h00, 8'h00, 7'b0));
        // add R3, R3 (X==Y)
        step("dbl_t0", 1, ins(3'b010, 3'd3, 3'd3), ex(8'h00, 8'h00, IR));
        step("dbl_t1", 0, 16'h0000, ex(8'h00, 8'h08, AI));
        step("dbl_t2", 0, 16'h0000, ex(8'h00, 8'h08, GI));
        step("dbl_t3", 0, 16'h0000, ex(8'h08, 8'h00, GO | DN));
        // Run held high: fetches at cycles 0, 2, 6
        step("bb_c0_fetch", 1, ins(3'b001, 3'd7, 3'd0), ex(8'h00, 8'h00, IR));
        step("bb_c1_mvi", 1, 16'h1234, ex(8'h80, 8'h00, DI | DN));
        step("bb_c2_fetch", 1, ins(3'b010, 3'd0, 3'd6), ex(8'h00, 8'h00, IR));
        step("bb_c3_add", 1, 16'hFFFF, ex(8'h00, 8'h01, AI));
        step("bb_c4_add", 1, 16'hFFFF, ex(8'h00, 8'h40, GI));
        step("bb_c5_add", 1, 16'hFFFF, ex(8'h01, 8'h00, GO | DN));
        step("bb_c6_fetch", 1, ins(3'b000, 3'd4, 3'd1), ex(8'h00, 8'h00, IR));
        step("bb_c7_mv", 1, 16'hFFFF, ex(8'h10, 8'h02, DN));
        // Run dropped in T2 does not abort
        step("rl_t0", 1, ins(3'b011, 3'd6, 3'd2), ex(8'h00, 8'h00, IR));
        step("rl_t1", 1, 16'h0000, ex(8'h00, 8'h40, AI));
        step("rl_t2", 0, 16'h0000, ex(8'h00, 8'h04, GI | AS));
        step("rl_t3", 0, 16'h0000, ex(8'h40, 8'h00, GO | DN));
        step("rl_idle", 0, 16'h0000, ex(8'h00, 8'h00, 7'b0));
        // reset in T2 of an add
        step("ra_t0", 1, ins(3'b010, 3'd5, 3'd4), ex(8'h00, 8'h00, IR));
        step("ra_t1", 1, 16'h0000, ex(8'h00, 8'h20, AI));
        Resetn = 1'b0;
        #1;
        check("ra_t2_reset", 32'(outs), 32'd0);
        @(negedge Clock);
        check("ra_reset_held", 32'(outs), 32'd0);
        Resetn = 1'b1;
        step("ra_after_run", 1, ins(3'b111, 3'd0, 3'd0), ex(8'h00, 8'h00, IR));
        step("ra_after_nop", 0, 16'h0000, ex(8'h00, 8'h00, DN));
        step("ra_idle", 0, 16'h0000, ex(8'h00, 8'h00, 7'b0));
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
